spi_sram_arbiter: RTL and testbench

Two-master Wishbone arbiter sharing the single `spi_sram` port between the SERV instruction bus (read-only) and data bus (read/write). It sits between the CPU buses and the SPI SRAM controller. It serialises accesses, routes read data and acks back to the granted master, and forces the one-cycle `cyc` gap the SRAM controller needs between transactions so that no access is issued twice.

---
 rtl/spi_sram_arbiter.sv | 118 +++++++++++
 tb/tb_spi_sram_arbiter.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_arbiter.sv
`default_nettype none
// ==== spi_sram_arbiter : ibus/dbus Wishbone arbiter in front of one SPI SRAM controller ====
// ==== rev 1.0                                                                          ====
module spi_sram_arbiter #(
    parameter int AW         = 14,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_cyc,
    input  logic [AW-1:0] i_adr,
    output logic [31:0]   i_dat,
    output logic          i_ack,
    input  logic          d_cyc,
    input  logic [AW-1:0] d_adr,
    input  logic          d_we,
    input  logic [31:0]   d_dat_w,
    input  logic [3:0]    d_sel,
    output logic [31:0]   d_dat,
    output logic          d_ack,
    output logic          s_cyc,
    output logic [AW-1:0] s_adr,
    output logic          s_we,
    output logic [31:0]   s_dat_w,
    output logic [3:0]    s_sel,
    input  logic [31:0]   s_dat_r,
    input  logic          s_ack,
    output logic [1:0]    grant,
    output logic          busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic LAST_IBUS = 1'b0;

    logic [1:0] state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_q, last_d;
    logic       w_pick_dbus;
    logic       w_ack_ok;

    // Contention goes to dbus in fixed mode, otherwise to whoever was not served last.
    always_comb begin
        w_pick_dbus = d_cyc;
        if (i_cyc && d_cyc) begin
            w_pick_dbus = (FIXED_PRIO != 0) ? 1'b1 : (last_q == LAST_IBUS);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (i_cyc || d_cyc) begin
                    state_d = S_BUSY;
                    grant_d = w_pick_dbus ? 2'b10 : 2'b01;
                    last_d  = w_pick_dbus;
                end
            end
            S_BUSY: begin
                if (s_ack) begin
                    state_d = S_GAP;
                    grant_d = 2'b00;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            last_q  <= LAST_IBUS;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // S_GAP holds s_cyc low one cycle so the controller cannot relaunch the finished access.
    assign s_cyc    = (state_q == S_BUSY);
    assign busy     = (state_q == S_BUSY) || (state_q == S_GAP);
    assign grant    = grant_q;
    assign w_ack_ok = s_ack && (state_q == S_BUSY);
    assign i_ack    = w_ack_ok && grant_q[0];
    assign d_ack    = w_ack_ok && grant_q[1];
    assign i_dat    = s_dat_r;
    assign d_dat    = s_dat_r;

    always_comb begin
        s_adr   = '0;
        s_we    = 1'b0;
        s_sel   = 4'b0000;
        s_dat_w = 32'h0;
        if (grant_q[1]) begin
            s_adr   = d_adr;
            s_we    = d_we;
            s_sel   = d_sel;
            s_dat_w = d_dat_w;
        end else if (grant_q[0]) begin
            s_adr   = i_adr;
            s_sel   = 4'b1111;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_arbiter.sv
`default_nettype none
// tb_spi_sram_arbiter: directed scenarios plus randomized traffic against a transaction-level model,
// on one round-robin instance (unit 0) and one fixed-priority instance (unit 1).
module tb_spi_sram_arbiter;
    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          i_cyc, d_cyc, d_we, spur_ack;
    logic [AW-1:0] i_adr, d_adr;
    logic [31:0]   d_dat_w;
    logic [3:0]    d_sel;

    logic [31:0]   i_dat_v [2];
    logic [31:0]   d_dat_v [2];
    logic [31:0]   s_dat_w_v [2];
    logic [31:0]   s_dat_r_v [2];
    logic          i_ack_v [2];
    logic          d_ack_v [2];
    logic          s_cyc_v [2];
    logic          s_we_v [2];
    logic          busy_v [2];
    logic          ctl_ack [2];
    logic          s_ack_in [2];
    logic [AW-1:0] s_adr_v [2];
    logic [3:0]    s_sel_v [2];
    logic [1:0]    grant_v [2];

    assign s_ack_in[0] = ctl_ack[0] | spur_ack;
    assign s_ack_in[1] = ctl_ack[1] | spur_ack;

    spi_sram_arbiter #(.AW(AW), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst(rst),
        .i_cyc(i_cyc), .i_adr(i_adr), .i_dat(i_dat_v[0]), .i_ack(i_ack_v[0]),
        .d_cyc(d_cyc), .d_adr(d_adr), .d_we(d_we), .d_dat_w(d_dat_w), .d_sel(d_sel),
        .d_dat(d_dat_v[0]), .d_ack(d_ack_v[0]),
        .s_cyc(s_cyc_v[0]), .s_adr(s_adr_v[0]), .s_we(s_we_v[0]), .s_dat_w(s_dat_w_v[0]),
        .s_sel(s_sel_v[0]), .s_dat_r(s_dat_r_v[0]), .s_ack(s_ack_in[0]),
        .grant(grant_v[0]), .busy(busy_v[0])
    );

    spi_sram_arbiter #(.AW(AW), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .i_cyc(i_cyc), .i_adr(i_adr), .i_dat(i_dat_v[1]), .i_ack(i_ack_v[1]),
        .d_cyc(d_cyc), .d_adr(d_adr), .d_we(d_we), .d_dat_w(d_dat_w), .d_sel(d_sel),
        .d_dat(d_dat_v[1]), .d_ack(d_ack_v[1]),
        .s_cyc(s_cyc_v[1]), .s_adr(s_adr_v[1]), .s_we(s_we_v[1]), .s_dat_w(s_dat_w_v[1]),
        .s_sel(s_sel_v[1]), .s_dat_r(s_dat_r_v[1]), .s_ack(s_ack_in[1]),
        .grant(grant_v[1]), .busy(busy_v[1])
    );

    function automatic logic [31:0] init_word(input int a);
        return 32'h12345678 + 32'(a - 16) * 32'h01000193;
    endfunction

    // SRAM controller model: acks after a random wait, 64-word memory with byte enables.
    int          ctl_first;
    int          ctl_lat_max;
    int          ctl_wait [2];
    logic [31:0] ctl_mem [2][64];

    always @(posedge clk or posedge rst) begin
        for (int n = 0; n < 2; n++) begin
            if (rst) begin
                ctl_ack[n]   <= 1'b0;
                ctl_wait[n]  <= ctl_first;
                s_dat_r_v[n] <= 32'h0;
                for (int a = 0; a < 64; a++) ctl_mem[n][a] <= init_word(a);
            end else begin
                ctl_ack[n] <= 1'b0;
                if (s_cyc_v[n] && !ctl_ack[n]) begin
                    if (ctl_wait[n] == 0) begin
                        ctl_ack[n]   <= 1'b1;
                        s_dat_r_v[n] <= ctl_mem[n][s_adr_v[n][5:0]];
                        if (s_we_v[n]) begin
                            for (int b = 0; b < 4; b++)
                                if (s_sel_v[n][b])
                                    ctl_mem[n][s_adr_v[n][5:0]][8*b +: 8] <= s_dat_w_v[n][8*b +: 8];
                        end
                        ctl_wait[n] <= $urandom_range(ctl_lat_max, 0);
                    end else begin
                        ctl_wait[n] <= ctl_wait[n] - 1;
                    end
                end
            end
        end
    end

    logic          u;
    logic [1:0]    v_grant;
    logic          v_busy, v_s_cyc, v_s_we, v_i_ack, v_d_ack, v_s_ack;
    logic [AW-1:0] v_s_adr;
    logic [3:0]    v_s_sel;
    logic [31:0]   v_s_dat_w, v_i_dat, v_d_dat;

    always_comb begin
        v_grant   = grant_v[u];
        v_busy    = busy_v[u];
        v_s_cyc   = s_cyc_v[u];
        v_s_we    = s_we_v[u];
        v_i_ack   = i_ack_v[u];
        v_d_ack   = d_ack_v[u];
        v_s_ack   = s_ack_in[u];
        v_s_adr   = s_adr_v[u];
        v_s_sel   = s_sel_v[u];
        v_s_dat_w = s_dat_w_v[u];
        v_i_dat   = i_dat_v[u];
        v_d_dat   = d_dat_v[u];
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ref_mem [64];

    task automatic do_reset(input int first_lat);
        ctl_first = first_lat;
        i_cyc = 0; d_cyc = 0; d_we = 0; i_adr = '0; d_adr = '0;
        d_dat_w = 32'h0; d_sel = 4'h0; spur_ack = 0;
        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        for (int a = 0; a < 64; a++) ref_mem[a] = init_word(a);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; i_cyc = 1; d_cyc = 1; i_adr = 14'h3; d_adr = 14'h4;
        d_we = 1; d_sel = 4'hF; d_dat_w = 32'hDEADBEEF; spur_ack = 1;
        for (int k = 0; k < 2; k++) begin
            u = 1'(k); #1;
            n_tests++;
            if ({v_grant, v_s_cyc, v_busy, v_i_ack, v_d_ack, v_s_we} !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl unit%0d: got grant=%b s_cyc=%b busy=%b i_ack=%b d_ack=%b s_we=%b, expected all 0",
                         k, v_grant, v_s_cyc, v_busy, v_i_ack, v_d_ack, v_s_we);
            end
            n_tests++;
            if ({v_s_adr, v_s_sel, v_s_dat_w} !== '0) begin
                n_fail++;
                $display("FAIL reset_data unit%0d: got s_adr=%h s_sel=%b s_dat_w=%h, expected 0", k, v_s_adr, v_s_sel, v_s_dat_w);
            end
        end
        spur_ack = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            u = 1'(k); #1;
            n_tests++;
            if (v_grant !== 2'b10) begin
                n_fail++;
                $display("FAIL first_contention unit%0d: got grant=%b, expected 10", k, v_grant);
            end
        end
    endtask

    task automatic test_ibus_read();
        logic got, dbad;
        logic [31:0] dat;
        do_reset(0); u = 0;
        i_cyc = 1; i_adr = 14'h0010;
        @(negedge clk);
        n_tests++;
        if ({v_s_cyc, v_grant} !== 3'b101) begin
            n_fail++;
            $display("FAIL ib_launch: got s_cyc=%b grant=%b, expected 1/01", v_s_cyc, v_grant);
        end
        n_tests++;
        if ({v_s_adr, v_s_we, v_s_sel, v_s_dat_w} !== {14'h0010, 1'b0, 4'hF, 32'h0}) begin
            n_fail++;
            $display("FAIL ib_mux: got adr=%h we=%b sel=%b dat=%h, expected 0010/0/1111/0", v_s_adr, v_s_we, v_s_sel, v_s_dat_w);
        end
        got = 0; dbad = 0; dat = 32'h0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (v_d_ack) dbad = 1;
            if (v_i_ack) begin got = 1; dat = v_i_dat; end
        end
        i_cyc = 0;
        n_tests++;
        if (!got || dbad || dat !== 32'h12345678) begin
            n_fail++;
            $display("FAIL ib_ack: got ack=%b d_ack_seen=%b i_dat=%h, expected 1/0/12345678", got, dbad, dat);
        end
        @(negedge clk);
        n_tests++;
        if ({v_i_ack, v_s_cyc, v_busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL ib_after: got i_ack=%b s_cyc=%b busy=%b, expected 0/0/1", v_i_ack, v_s_cyc, v_busy);
        end
    endtask

    task automatic test_dbus_write();
        logic got, ibad;
        logic [31:0] dat;
        do_reset(0); u = 0;
        d_cyc = 1; d_adr = 14'd5; d_we = 1; d_sel = 4'b0100; d_dat_w = 32'h00AB0000;
        @(negedge clk);
        n_tests++;
        if ({v_grant, v_s_adr, v_s_we, v_s_sel, v_s_dat_w} !== {2'b10, 14'd5, 1'b1, 4'b0100, 32'h00AB0000}) begin
            n_fail++;
            $display("FAIL dw_mux: got grant=%b adr=%h we=%b sel=%b dat=%h, expected 10/0005/1/0100/00ab0000",
                     v_grant, v_s_adr, v_s_we, v_s_sel, v_s_dat_w);
        end
        got = 0; ibad = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (v_i_ack) ibad = 1;
            if (v_d_ack) got = 1;
        end
        d_cyc = 0;
        n_tests++;
        if (!got || ibad) begin
            n_fail++;
            $display("FAIL dw_ack: got d_ack=%b i_ack_seen=%b, expected 1/0", got, ibad);
        end
        @(negedge clk);
        n_tests++;
        if ({v_s_cyc, v_d_ack} !== 2'b00) begin
            n_fail++;
            $display("FAIL dw_gap: got s_cyc=%b d_ack=%b, expected 0/0", v_s_cyc, v_d_ack);
        end
        i_cyc = 1; i_adr = 14'd5;
        got = 0; dat = 32'h0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (v_i_ack) begin got = 1; dat = v_i_dat; end
        end
        i_cyc = 0;
        n_tests++;
        if (!got || dat !== ((init_word(5) & 32'hFF00FFFF) | 32'h00AB0000)) begin
            n_fail++;
            $display("FAIL dw_readback: got ack=%b dat=%h, expected 1/%h", got, dat,
                     (init_word(5) & 32'hFF00FFFF) | 32'h00AB0000);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [$];
        logic [1:0] prev, exp;
        do_reset(1); u = 0;
        i_cyc = 1; i_adr = 14'd3; d_cyc = 1; d_adr = 14'd7; d_we = 0; d_sel = 4'hF;
        prev = 2'b00;
        for (int k = 0; k < 200 && order.size() < 4; k++) begin
            @(negedge clk);
            if (v_grant != 2'b00 && prev == 2'b00) order.push_back(v_grant);
            prev = v_grant;
        end
        i_cyc = 0; d_cyc = 0;
        n_tests++;
        if (order.size() != 4) begin
            n_fail++;
            $display("FAIL rr_count: got %0d grants, expected 4", order.size());
        end
        for (int t = 0; t < order.size(); t++) begin
            exp = (t % 2 == 0) ? 2'b10 : 2'b01;
            n_tests++;
            if (order[t] !== exp) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got grant=%b, expected %b", t, order[t], exp);
            end
        end
    endtask

    task automatic test_fixed_prio();
        logic [1:0] order [$];
        logic [1:0] prev, exp;
        int dn;
        do_reset(1); u = 1;
        i_cyc = 1; i_adr = 14'd2; d_cyc = 1; d_adr = 14'd9; d_we = 0; d_sel = 4'hF;
        prev = 2'b00; dn = 0;
        for (int k = 0; k < 200 && order.size() < 4; k++) begin
            @(negedge clk);
            if (v_grant != 2'b00 && prev == 2'b00) order.push_back(v_grant);
            prev = v_grant;
            if (v_d_ack) begin
                dn++;
                if (dn == 3) d_cyc = 0;
            end
        end
        i_cyc = 0; d_cyc = 0;
        n_tests++;
        if (order.size() != 4) begin
            n_fail++;
            $display("FAIL fp_count: got %0d grants, expected 4", order.size());
        end
        for (int t = 0; t < order.size(); t++) begin
            exp = (t < 3) ? 2'b10 : 2'b01;
            n_tests++;
            if (order[t] !== exp) begin
                n_fail++;
                $display("FAIL fp_order[%0d]: got grant=%b, expected %b", t, order[t], exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(10); u = 0;
        d_cyc = 1; d_adr = 14'd9; d_we = 1; d_sel = 4'hF; d_dat_w = 32'hCAFEF00D;
        @(negedge clk);
        n_tests++;
        if ({v_s_cyc, v_grant} !== 3'b110) begin
            n_fail++;
            $display("FAIL rm_before: got s_cyc=%b grant=%b, expected 1/10", v_s_cyc, v_grant);
        end
        #2 rst = 1; i_cyc = 1;
        #1;
        n_tests++;
        if ({v_s_cyc, v_grant, v_busy, v_d_ack, v_i_ack} !== 6'b0 || {v_s_adr, v_s_sel, v_s_dat_w, v_s_we} !== '0) begin
            n_fail++;
            $display("FAIL rm_async: got s_cyc=%b grant=%b busy=%b adr=%h sel=%b dat=%h we=%b, expected all 0",
                     v_s_cyc, v_grant, v_busy, v_s_adr, v_s_sel, v_s_dat_w, v_s_we);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        n_tests++;
        if (v_grant !== 2'b10) begin
            n_fail++;
            $display("FAIL rm_last_reset: got grant=%b, expected 10", v_grant);
        end
        i_cyc = 0; d_cyc = 0;
    endtask

    task automatic test_spurious_ack();
        do_reset(0); u = 0;
        @(negedge clk);
        spur_ack = 1; #1;
        n_tests++;
        if ({v_i_ack, v_d_ack, v_busy, v_s_cyc, v_grant} !== 6'b0) begin
            n_fail++;
            $display("FAIL spur_ack: got i_ack=%b d_ack=%b busy=%b s_cyc=%b grant=%b, expected all 0",
                     v_i_ack, v_d_ack, v_busy, v_s_cyc, v_grant);
        end
        @(negedge clk);
        spur_ack = 0; i_cyc = 1; i_adr = 14'd1;
        #1;
        n_tests++;
        if ({v_busy, v_grant} !== 3'b000) begin
            n_fail++;
            $display("FAIL spur_state: got busy=%b grant=%b, expected 0/00", v_busy, v_grant);
        end
        @(negedge clk);
        n_tests++;
        if (v_grant !== 2'b01) begin
            n_fail++;
            $display("FAIL spur_next_grant: got grant=%b, expected 01", v_grant);
        end
        i_cyc = 0;
    endtask

    task automatic test_drop_cyc();
        logic got;
        logic [31:0] dat;
        do_reset(3); u = 0;
        i_cyc = 1; i_adr = 14'd2;
        @(negedge clk);
        i_cyc = 0;
        got = 0; dat = 32'h0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (v_i_ack) begin got = 1; dat = v_i_dat; end
        end
        n_tests++;
        if (!got || dat !== init_word(2)) begin
            n_fail++;
            $display("FAIL drop_ack: got ack=%b dat=%h, expected 1/%h", got, dat, init_word(2));
        end
        @(negedge clk);
        n_tests++;
        if ({v_s_cyc, v_busy, v_grant} !== 4'b0100) begin
            n_fail++;
            $display("FAIL drop_gap: got s_cyc=%b busy=%b grant=%b, expected 0/1/00", v_s_cyc, v_busy, v_grant);
        end
        @(negedge clk);
        n_tests++;
        if ({v_s_cyc, v_busy, v_grant} !== 4'b0000) begin
            n_fail++;
            $display("FAIL drop_idle: got s_cyc=%b busy=%b grant=%b, expected 0/0/00", v_s_cyc, v_busy, v_grant);
        end
    endtask

    // Model: owner 0 = none, 1 = ibus, 2 = dbus; the arbiter may grant again two edges after an ack.
    task automatic test_random_traffic(input logic unit, input int ncyc);
        int owner, free_at, last, n_done;
        logic req_i, req_d, ack_e, exp_iack, exp_dack, exp_busy;
        logic [1:0] exp_grant;
        logic [AW+36:0] exp_mux;
        do_reset(0); u = unit; ctl_lat_max = 4;
        owner = 0; free_at = 0; last = 1; n_done = 0;
        req_i = 0; req_d = 0; ack_e = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (owner != 0 && ack_e) begin
                owner = 0;
                free_at = k + 2;
            end else if (owner == 0 && k >= free_at && (req_i || req_d)) begin
                if (req_i && req_d) owner = (unit == 1'b1 || last == 1) ? 2 : 1;
                else owner = req_d ? 2 : 1;
                last = owner;
            end
            exp_grant = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
            exp_busy  = (owner != 0) || (k + 1 < free_at);
            n_tests++;
            if (v_grant !== exp_grant || v_s_cyc !== (owner != 0) || v_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL rand_fsm unit%0d cyc%0d: got grant=%b s_cyc=%b busy=%b, expected grant=%b s_cyc=%b busy=%b",
                         unit, k, v_grant, v_s_cyc, v_busy, exp_grant, owner != 0, exp_busy);
            end
            exp_mux = (owner == 1) ? {i_adr, 1'b0, 4'hF, 32'h0} :
                      (owner == 2) ? {d_adr, d_we, d_sel, d_dat_w} : '0;
            n_tests++;
            if ({v_s_adr, v_s_we, v_s_sel, v_s_dat_w} !== exp_mux) begin
                n_fail++;
                $display("FAIL rand_mux unit%0d cyc%0d: got %h, expected %h", unit, k,
                         {v_s_adr, v_s_we, v_s_sel, v_s_dat_w}, exp_mux);
            end
            exp_iack = v_s_ack && owner == 1;
            exp_dack = v_s_ack && owner == 2;
            n_tests++;
            if ({v_i_ack, v_d_ack} !== {exp_iack, exp_dack}) begin
                n_fail++;
                $display("FAIL rand_ack unit%0d cyc%0d: got i_ack=%b d_ack=%b, expected %b/%b",
                         unit, k, v_i_ack, v_d_ack, exp_iack, exp_dack);
            end
            if (exp_iack) begin
                n_done++;
                n_tests++;
                if (v_i_dat !== ref_mem[i_adr[5:0]]) begin
                    n_fail++;
                    $display("FAIL rand_idat unit%0d cyc%0d: got %h, expected %h", unit, k, v_i_dat, ref_mem[i_adr[5:0]]);
                end
            end
            if (exp_dack) begin
                n_done++;
                if (d_we) begin
                    for (int b = 0; b < 4; b++)
                        if (d_sel[b]) ref_mem[d_adr[5:0]][8*b +: 8] = d_dat_w[8*b +: 8];
                end else begin
                    n_tests++;
                    if (v_d_dat !== ref_mem[d_adr[5:0]]) begin
                        n_fail++;
                        $display("FAIL rand_ddat unit%0d cyc%0d: got %h, expected %h", unit, k, v_d_dat, ref_mem[d_adr[5:0]]);
                    end
                end
            end
            if (!i_cyc || exp_iack) begin
                i_cyc = ($urandom_range(99) < 60);
                i_adr = AW'($urandom_range(63));
            end
            if (!d_cyc || exp_dack) begin
                d_cyc   = ($urandom_range(99) < 60);
                d_adr   = AW'($urandom_range(63));
                d_we    = 1'($urandom_range(1));
                d_sel   = 4'($urandom_range(15, 1));
                d_dat_w = $urandom;
            end
            req_i = i_cyc; req_d = d_cyc; ack_e = v_s_ack;
        end
        i_cyc = 0; d_cyc = 0; ctl_lat_max = 3;
        n_tests++;
        if (n_done < ncyc / 20) begin
            n_fail++;
            $display("FAIL rand_progress unit%0d: got %0d completed transfers, expected at least %0d", unit, n_done, ncyc / 20);
        end
    endtask

    initial begin
        rst = 1; u = 0; ctl_first = 0; ctl_lat_max = 3; spur_ack = 0;
        i_cyc = 0; d_cyc = 0; d_we = 0; i_adr = '0; d_adr = '0; d_dat_w = 32'h0; d_sel = 4'h0;
        test_reset();
        test_ibus_read();
        test_dbus_write();
        test_round_robin();
        test_fixed_prio();
        test_reset_mid();
        test_spurious_ack();
        test_drop_cyc();
        test_random_traffic(1'b0, 600);
        test_random_traffic(1'b1, 600);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
